// File: rtl/load_store_sizer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : load_store_sizer_if
// Brief    : Control/memory-side bundle of the sub-word load/store engine.
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_sizer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic [31:0] load_data;

    modport master (
        output start, op, addr, store_data, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, busy, done, misaligned, load_data
    );

    modport slave (
        input  start, op, addr, store_data, mem_rdata,
        output mem_addr, mem_wdata, mem_we, busy, done, misaligned, load_data
    );
endinterface
`default_nettype wire

// File: rtl/load_store_sizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : load_store_sizer
// Brief    : Sub-word load/store engine over a word-addressed data memory;
//            byte/half stores are done as read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_sizer #(
    parameter int MEM_LATENCY = 1
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    load_store_sizer_if.slave   bus
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MEM_LATENCY - 1);

    localparam logic [2:0] c_op_lw  = 3'b000;
    localparam logic [2:0] c_op_lh  = 3'b001;
    localparam logic [2:0] c_op_lhu = 3'b010;
    localparam logic [2:0] c_op_lb  = 3'b011;
    localparam logic [2:0] c_op_lbu = 3'b100;
    localparam logic [2:0] c_op_sw  = 3'b101;
    localparam logic [2:0] c_op_sh  = 3'b110;
    localparam logic [2:0] c_op_sb  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [1:0]         r_addr_lo;
    logic [15:0]        r_sdata;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_mem_we;
    logic               r_done;
    logic               r_mis;
    logic [31:0]        r_load;

    logic               w_fault;
    logic               w_is_load;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;
    logic [31:0]        w_merge;

    // Alignment is judged on the incoming request, before anything is latched.
    always_comb begin
        w_fault = 1'b0;
        case (bus.op)
            c_op_lw, c_op_sw:           w_fault = |bus.addr[1:0];
            c_op_lh, c_op_lhu, c_op_sh: w_fault = bus.addr[0];
            default:                    w_fault = 1'b0;
        endcase
    end

    assign w_is_load = (r_op <= c_op_lbu);

    always_comb begin
        w_byte = bus.mem_rdata[7:0];
        case (r_addr_lo)
            2'd0: w_byte = bus.mem_rdata[7:0];
            2'd1: w_byte = bus.mem_rdata[15:8];
            2'd2: w_byte = bus.mem_rdata[23:16];
            2'd3: w_byte = bus.mem_rdata[31:24];
            default: w_byte = bus.mem_rdata[7:0];
        endcase
        w_half = r_addr_lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        case (r_op)
            c_op_lb:  w_load = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: w_load = {24'd0, w_byte};
            c_op_lh:  w_load = {{16{w_half[15]}}, w_half};
            c_op_lhu: w_load = {16'd0, w_half};
            default:  w_load = bus.mem_rdata;
        endcase
    end

    // Merge the latched store lane into the freshly read word.
    always_comb begin
        w_merge = bus.mem_rdata;
        if (r_op == c_op_sb) begin
            case (r_addr_lo)
                2'd0: w_merge[7:0]   = r_sdata[7:0];
                2'd1: w_merge[15:8]  = r_sdata[7:0];
                2'd2: w_merge[23:16] = r_sdata[7:0];
                2'd3: w_merge[31:24] = r_sdata[7:0];
                default: w_merge = bus.mem_rdata;
            endcase
        end else if (r_op == c_op_sh) begin
            if (r_addr_lo[1]) begin
                w_merge[31:16] = r_sdata;
            end else begin
                w_merge[15:0] = r_sdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_sdata     <= 16'd0;
            r_cnt       <= '0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_we    <= 1'b0;
            r_done      <= 1'b0;
            r_mis       <= 1'b0;
            r_load      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done   <= 1'b0;
                    r_mis    <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (bus.start) begin
                        r_op       <= bus.op;
                        r_addr_lo  <= bus.addr[1:0];
                        r_sdata    <= bus.store_data[15:0];
                        r_mem_addr <= {bus.addr[31:2], 2'b00};
                        r_cnt      <= '0;
                        if (w_fault) begin
                            r_done  <= 1'b1;
                            r_mis   <= 1'b1;
                            r_state <= S_DONE;
                        end else if (bus.op == c_op_sw) begin
                            r_mem_wdata <= bus.store_data;
                            r_mem_we    <= 1'b1;
                            r_state     <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end

                S_READ: begin
                    if (r_cnt == c_cnt_last) begin
                        r_cnt <= '0;
                        if (w_is_load) begin
                            r_load  <= w_load;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_mem_wdata <= w_merge;
                            r_mem_we    <= 1'b1;
                            r_state     <= S_WRITE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_WRITE: begin
                    r_mem_we <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_mis   <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_mem_we <= 1'b0;
                    r_done   <= 1'b0;
                    r_mis    <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_we     = r_mem_we;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.misaligned = r_mis;
    assign bus.load_data  = r_load;

endmodule
`default_nettype wire

// File: tb/tb_load_store_sizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_load_store_sizer
// Brief    : Self-checking bench; one engine at latency 1, one at latency 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_sizer;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3;
    localparam logic [2:0] LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    load_store_sizer_if ifa();
    load_store_sizer_if ifb();

    load_store_sizer #(.MEM_LATENCY(1)) u_dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    load_store_sizer #(.MEM_LATENCY(3)) u_dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb.slave));

    // Shared word memory; the latency-3 port sees its address two clocks late.
    logic [31:0] mem   [0:255];
    logic [31:0] model [0:255];
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;
    logic [31:0] b_d1, b_d2;

    always @(posedge clk) begin
        if (bd_we)            mem[bd_idx] <= bd_data;
        else if (ifa.mem_we)  mem[ifa.mem_addr[9:2]] <= ifa.mem_wdata;
        else if (ifb.mem_we)  mem[ifb.mem_addr[9:2]] <= ifb.mem_wdata;
        b_d1 <= ifb.mem_addr;
        b_d2 <= b_d1;
    end
    assign ifa.mem_rdata = mem[ifa.mem_addr[9:2]];
    assign ifb.mem_rdata = mem[b_d2[9:2]];

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_ld [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int d, input logic s, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] sd);
        if (d == 0) begin
            ifa.start = s; ifa.op = o; ifa.addr = a; ifa.store_data = sd;
        end else begin
            ifb.start = s; ifb.op = o; ifb.addr = a; ifb.store_data = sd;
        end
    endtask

    task automatic sample(input int d, output logic dn, output logic we, output logic mis,
                          output logic bsy, output logic [31:0] wd, output logic [31:0] ma,
                          output logic [31:0] ld);
        if (d == 0) begin
            dn = ifa.done; we = ifa.mem_we; mis = ifa.misaligned; bsy = ifa.busy;
            wd = ifa.mem_wdata; ma = ifa.mem_addr; ld = ifa.load_data;
        end else begin
            dn = ifb.done; we = ifb.mem_we; mis = ifb.misaligned; bsy = ifb.busy;
            wd = ifb.mem_wdata; ma = ifb.mem_addr; ld = ifb.load_data;
        end
    endtask

    // Reference rules, written as plain arithmetic on the word.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] w,
                                             input logic [31:0] a);
        longint v;
        if (op == LB || op == LBU) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (op == LB && v > 127) v = v - 256;
        end else if (op == LH || op == LHU) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (op == LH && v > 32767) v = v - 65536;
        end else begin
            v = w;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] op, input logic [31:0] w,
                                              input logic [31:0] a, input logic [31:0] sd);
        logic [31:0] mask;
        int sh;
        if (op == SW) return sd;
        sh   = (op == SB) ? 8 * a[1:0] : 16 * a[1];
        mask = ((op == SB) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((sd << sh) & mask);
    endfunction

    task automatic do_op(input int d, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] sd);
        int          lat, exp_n, n, we_cnt;
        logic        f, st, got, extra;
        logic        dn, we, mis, bsy;
        logic [31:0] wd, ma, ld, exp_w;
        lat   = (d == 0) ? 1 : 3;
        st    = (op >= SW);
        f     = ((op == LW || op == SW) && a[1:0] != 2'd0) ||
                ((op == LH || op == LHU || op == SH) && a[0]);
        exp_n = f ? 1 : (op == SW) ? 2 : st ? lat + 2 : lat + 1;
        exp_w = ref_store(op, model[a[9:2]], a, sd);
        @(negedge clk);
        set_in(d, 1'b1, op, a, sd);
        n = 0; got = 1'b0; we_cnt = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            sample(d, dn, we, mis, bsy, wd, ma, ld);
            if (we) begin
                we_cnt++;
                check("wr_data", wd, exp_w);
                check("wr_addr", ma, {a[31:2], 2'b00});
            end
            if (dn) begin
                got = 1'b1;
                set_in(d, 1'b0, 3'd0, 32'd0, 32'd0);
                check("done_cycle", n, exp_n);
                check("misaligned", {31'd0, mis}, {31'd0, f});
                if (!f && !st) exp_ld[d] = ref_load(op, model[a[9:2]], a);
                check("load_data", ld, exp_ld[d]);
            end else begin
                // Noise while busy: must neither be queued nor disturb latched fields.
                set_in(d, 1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom);
            end
        end
        check("done_seen", {31'd0, got}, 32'd1);
        check("we_cycles", we_cnt, (st && !f) ? 1 : 0);
        if (st && !f) model[a[9:2]] = exp_w;
        extra = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sample(d, dn, we, mis, bsy, wd, ma, ld);
            if (k == 0) check("idle_busy", {31'd0, bsy}, 32'd0);
            extra = extra | dn | we;
        end
        check("no_extra_done", {31'd0, extra}, 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        reset_n   = 1'b0;
        bd_we     = 1'b0;
        bd_idx    = 8'd0;
        bd_data   = 32'd0;
        exp_ld[0] = 32'd0;
        exp_ld[1] = 32'd0;
        set_in(0, 1'b0, 3'd0, 32'd0, 32'd0);
        set_in(1, 1'b0, 3'd0, 32'd0, 32'd0);
        for (int i = 64; i < 80; i++) begin
            w = (i == 64) ? 32'h8899AABB : $urandom;
            model[i] = w;
            @(negedge clk);
            bd_we = 1'b1; bd_idx = 8'(i); bd_data = w;
        end
        @(negedge clk);
        bd_we = 1'b0;

        check("rst_mem_addr", ifa.mem_addr, 32'd0);
        check("rst_load_data", ifa.load_data, 32'd0);
        check("rst_flags", {28'd0, ifa.done, ifa.busy, ifa.mem_we, ifa.misaligned}, 32'd0);
        check("rst_b_flags", {28'd0, ifb.done, ifb.busy, ifb.mem_we, ifb.misaligned}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        do_op(0, LB, 32'h103, $urandom);
        check("t1_lb", ifa.load_data, 32'hFFFFFF88);
        do_op(0, LHU, 32'h102, $urandom);
        check("t2_lhu", ifa.load_data, 32'h00008899);
        do_op(0, LH, 32'h100, $urandom);
        check("t2_lh", ifa.load_data, 32'hFFFFAABB);
        do_op(0, LW, 32'h100, $urandom);
        check("t2_lw", ifa.load_data, 32'h8899AABB);
        do_op(0, SB, 32'h101, 32'h12345677);
        check("t3_mem", mem[64], 32'h889977BB);
        do_op(0, LW, 32'h100, $urandom);
        check("t3_readback", ifa.load_data, 32'h889977BB);
        do_op(0, SW, 32'h102, $urandom);
        check("t4_ld_held", ifa.load_data, 32'h889977BB);

        // Reset pulled in the middle of the SH write cycle.
        @(negedge clk);
        set_in(0, 1'b1, SH, 32'h104, 32'hCAFE1234);
        @(negedge clk);
        set_in(0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("t5_we_before", {31'd0, ifa.mem_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_we_drop", {31'd0, ifa.mem_we}, 32'd0);
        check("t5_flags", {29'd0, ifa.done, ifa.busy, ifa.misaligned}, 32'd0);
        check("t5_mem_addr", ifa.mem_addr, 32'd0);
        check("t5_mem_wdata", ifa.mem_wdata, 32'd0);
        check("t5_load_data", ifa.load_data, 32'd0);
        exp_ld[0] = 32'd0;
        exp_ld[1] = 32'd0;
        @(negedge clk);
        check("t5_no_done", {31'd0, ifa.done}, 32'd0);
        reset_n = 1'b1;
        do_op(0, LW, 32'h104, $urandom);

        do_op(1, LW, 32'h108, $urandom);
        do_op(1, SH, 32'h10A, $urandom);
        do_op(1, LHU, 32'h10A, $urandom);

        for (int i = 0; i < 40; i++)
            do_op(0, 3'($urandom), 32'h100 + $urandom_range(0, 63), $urandom);
        for (int i = 0; i < 40; i++)
            do_op(1, 3'($urandom), 32'h100 + $urandom_range(0, 63), $urandom);

        for (int i = 64; i < 80; i++) check("mem_final", mem[i], model[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
